// File: rtl/i2s_rx_deser_pkg.sv
// rtl/i2s_rx_deser_pkg.sv - shared types and constants for the I2S receive deserializer
//
// Purpose : receiver state enum, default sample/slot widths, overrun counter width.
// Ports   : none (package i2s_pkg).
package i2s_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_SLOT_W = 32;
   localparam int OVR_CNT_W  = 16;

endpackage

// File: rtl/i2s_rx_deser_if.sv
// rtl/i2s_rx_deser_if.sv - stereo pair output handshake of the I2S receiver
//
// Purpose : carries the received left/right pair with a valid/ready handshake.
// Signals : out_left/out_right - sample pair, out_valid - pair available,
//           out_ready - consumer accepts when out_valid && out_ready.
// Modports: master (receiver side), slave (consumer side).
interface i2s_rx_deser_if
   import i2s_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [DATA_W-1:0] out_left;
   logic [DATA_W-1:0] out_right;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_left,
      output out_right,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_left,
      input  out_right,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/i2s_rx_deser_slot_shift.sv
// rtl/i2s_rx_deser_slot_shift.sv - per-slot MSB-first capture with bit counter
//
// Purpose : collects the first DATA_W bits of a slot MSB first, ignores the rest,
//           zero-fills missing LSBs of a short slot and flags it.
// Ports   : sclk, reset    - bit clock, async active-high reset
//           run            - low clears and holds the capture (receiver not locked)
//           bit_in         - serial bit for this cycle
//           last           - bit_in is the final bit of the slot; slot closes
//           slot_data      - slot value including bit_in (valid when last)
//           slot_short     - slot has fewer than DATA_W bits (valid when last)
module i2s_slot_shift #(
   parameter int DATA_W = 24,
   parameter int SLOT_W = 32
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              run,
   input  logic              bit_in,
   input  logic              last,
   output logic [DATA_W-1:0] slot_data,
   output logic              slot_short
);

   localparam int CNT_W = $clog2(SLOT_W + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0]  SHORT_LIM = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] MSB_ONE   = {1'b1, {(DATA_W-1){1'b0}}};

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;

   // Bit n of the slot lands at position DATA_W-1-n; once cnt reaches DATA_W the
   // mask shifts out to zero, so surplus bits drop and unfilled LSBs stay zero.
   assign slot_data  = bit_in ? (shreg | (MSB_ONE >> cnt)) : shreg;
   // cnt counts bits before the closing one, so DATA_W-1 or more means full.
   assign slot_short = (cnt < SHORT_LIM);

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (!run || last) begin
         cnt   <= '0;
         shreg <= '0;
      end else begin
         shreg <= slot_data;
         if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S receive deserializer producing stereo sample pairs
//
// Purpose : locks onto ws, captures left and right slots (one-bit I2S delay) and
//           presents each complete frame as a pair with valid/ready handshake.
// Ports   : sclk, reset  - bit clock, async active-high reset
//           ws_in, sd_in - word select (0 left, 1 right) and serial data
//           pair         - i2s_rx_deser_if.master: out_left/out_right/out_valid/out_ready
//           overrun      - pulse: completed frame dropped because pair still held
//           frame_err    - pulse: completed slot shorter than DATA_W bits
//           overrun_cnt  - saturating overrun count, only with I2S_RX_OVERRUN_CNT_EN
module i2s_rx_deser
   import i2s_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SLOT_W = DEF_SLOT_W
) (
   input  logic           sclk,
   input  logic           reset,
   input  logic           ws_in,
   input  logic           sd_in,
   i2s_rx_deser_if.master pair,
   output logic           overrun,
   output logic           frame_err
`ifdef I2S_RX_OVERRUN_CNT_EN
   ,
   output logic [OVR_CNT_W-1:0] overrun_cnt
`endif
);

   state_t            state;
   logic              ws_q;
   logic              sd_q;
   logic              edge_q;
   logic [DATA_W-1:0] left_hold;
   logic [DATA_W-1:0] slot_data;
   logic              slot_short;

   // edge_q marks that sd_q holds the bit sampled on the ws-change edge, i.e. the
   // final bit of the slot that just ended; ws_q already shows the new level.
   i2s_slot_shift #(
      .DATA_W (DATA_W),
      .SLOT_W (SLOT_W)
   ) u_slot_shift (
      .sclk       (sclk),
      .reset      (reset),
      .run        (state != SYNC),
      .bit_in     (sd_q),
      .last       (edge_q),
      .slot_data  (slot_data),
      .slot_short (slot_short)
   );

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state          <= SYNC;
         ws_q           <= 1'b0;
         sd_q           <= 1'b0;
         edge_q         <= 1'b0;
         left_hold      <= '0;
         pair.out_left  <= '0;
         pair.out_right <= '0;
         pair.out_valid <= 1'b0;
         overrun        <= 1'b0;
         frame_err      <= 1'b0;
`ifdef I2S_RX_OVERRUN_CNT_EN
         overrun_cnt    <= '0;
`endif
      end else begin
         ws_q      <= ws_in;
         sd_q      <= sd_in;
         edge_q    <= ws_in ^ ws_q;
         overrun   <= 1'b0;
         frame_err <= 1'b0;

         if (pair.out_valid && pair.out_ready) begin
            pair.out_valid <= 1'b0;
         end

         case (state)
            SYNC: begin
               if (edge_q && !ws_q) begin
                  state <= LEFT;
               end
            end
            LEFT: begin
               if (edge_q) begin
                  state     <= RIGHT;
                  left_hold <= slot_data;
                  frame_err <= slot_short;
               end
            end
            RIGHT: begin
               if (edge_q) begin
                  state     <= LEFT;
                  frame_err <= slot_short;
                  // A pair accepted this cycle frees the output for the new one.
                  if (!pair.out_valid || pair.out_ready) begin
                     pair.out_left  <= left_hold;
                     pair.out_right <= slot_data;
                     pair.out_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
`ifdef I2S_RX_OVERRUN_CNT_EN
                     if (overrun_cnt != '1) begin
                        overrun_cnt <= overrun_cnt + 1'b1;
                     end
`endif
                  end
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb/tb_i2s_rx_deser.sv - self-checking bench for i2s_rx_deser
`timescale 1ns/1ps
module tb_i2s_rx_deser;
   import i2s_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int SW = DEF_SLOT_W;

   logic sclk  = 1'b0;
   logic reset = 1'b1;
   logic ws_in = 1'b0;
   logic sd_in = 1'b0;
   logic overrun;
   logic frame_err;
`ifdef I2S_RX_OVERRUN_CNT_EN
   logic [OVR_CNT_W-1:0] overrun_cnt;
`endif

   i2s_rx_deser_if #(.DATA_W(DW)) pair ();

   i2s_rx_deser #(
      .DATA_W (DW),
      .SLOT_W (SW)
   ) dut (
      .sclk      (sclk),
      .reset     (reset),
      .ws_in     (ws_in),
      .sd_in     (sd_in),
      .pair      (pair),
      .overrun   (overrun),
      .frame_err (frame_err)
`ifdef I2S_RX_OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   always #5 sclk = ~sclk;

   int cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   logic [2*DW-1:0] exp_q[$];
   logic [2*DW-1:0] exp_pair;

   int   ovr_pulses   = 0;
   int   ferr_pulses  = 0;
   int   rise_cyc     = 0;
   int   run_len      = 0;
   int   last_run     = 0;
   int   pop_cyc      = 0;
   int   prev_pop_cyc = 0;
   int   fall_cyc     = 0;
   logic prev_hold    = 1'b0;
   logic [DW-1:0] prev_l = '0;
   logic [DW-1:0] prev_r = '0;
   logic pend = 1'b0;

   // Output monitor: pops the scoreboard on every accepted pair and checks that a
   // stalled pair holds still.
   always @(negedge sclk) begin
      #1;
      if (reset) begin
         prev_hold = 1'b0;
         run_len   = 0;
      end else begin
         if (overrun)   ovr_pulses++;
         if (frame_err) ferr_pulses++;
         if (pair.out_valid && run_len == 0) rise_cyc = cyc;
         if (pair.out_valid) begin
            run_len++;
         end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
         end
         if (prev_hold) begin
            compared++;
            if (pair.out_valid !== 1'b1 || pair.out_left !== prev_l || pair.out_right !== prev_r) begin
               mismatched++;
               $display("FAIL hold_stable: got valid=%b %h/%h required valid=1 %h/%h",
                        pair.out_valid, pair.out_left, pair.out_right, prev_l, prev_r);
            end
         end
         prev_hold = pair.out_valid && !pair.out_ready;
         prev_l    = pair.out_left;
         prev_r    = pair.out_right;
         if (pair.out_valid && pair.out_ready) begin
            prev_pop_cyc = pop_cyc;
            pop_cyc      = cyc;
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_pair: got %h/%h required no output",
                        pair.out_left, pair.out_right);
            end else begin
               exp_pair = exp_q.pop_front();
               if ({pair.out_left, pair.out_right} !== exp_pair) begin
                  mismatched++;
                  $display("FAIL pair_data: got %h/%h required %h/%h",
                           pair.out_left, pair.out_right, exp_pair[2*DW-1:DW], exp_pair[DW-1:0]);
               end
            end
         end
      end
   end

   function automatic logic bitval(input logic [DW-1:0] d, input int j);
      if (j >= 0 && j < DW) return d[DW-1-j];
      return 1'b0;
   endfunction

   // One ws half-period of len sclk cycles; the first cycle still carries the
   // previous slot's final bit (I2S one-bit delay).
   task automatic drive_slot(input logic level, input logic [DW-1:0] d, input int len, input int rdy_c);
      for (int c = 0; c < len; c++) begin
         @(negedge sclk);
         ws_in = level;
         sd_in = (c == 0) ? pend : bitval(d, c - 1);
         if (c == 0 && !level) fall_cyc = cyc;
         if (c == rdy_c) pair.out_ready = 1'b1;
      end
      pend = bitval(d, len - 1);
   endtask

   task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      exp_q.push_back({l, r});
   endtask

   task automatic check_zero_outputs(input string tag);
      compared++;
      if (pair.out_valid !== 1'b0) begin
         mismatched++; $display("FAIL %s_valid: got %b required 0", tag, pair.out_valid);
      end
      compared++;
      if (pair.out_left !== '0) begin
         mismatched++; $display("FAIL %s_left: got %h required 0", tag, pair.out_left);
      end
      compared++;
      if (pair.out_right !== '0) begin
         mismatched++; $display("FAIL %s_right: got %h required 0", tag, pair.out_right);
      end
      compared++;
      if (overrun !== 1'b0) begin
         mismatched++; $display("FAIL %s_overrun: got %b required 0", tag, overrun);
      end
      compared++;
      if (frame_err !== 1'b0) begin
         mismatched++; $display("FAIL %s_frame_err: got %b required 0", tag, frame_err);
      end
`ifdef I2S_RX_OVERRUN_CNT_EN
      compared++;
      if (overrun_cnt !== '0) begin
         mismatched++; $display("FAIL %s_overrun_cnt: got %0d required 0", tag, overrun_cnt);
      end
`endif
   endtask

   task automatic test_reset();
      pair.out_ready = 1'b1;
      repeat (3) @(negedge sclk);
      #2;
      check_zero_outputs("reset");
      @(negedge sclk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      drive_slot(1'b1, 24'h000000, SW, -1);
      drive_slot(1'b0, 24'h123456, SW, -1);
      drive_slot(1'b1, 24'hABCDEF, SW, -1);
      push_pair(24'h123456, 24'hABCDEF);
      drive_slot(1'b0, 24'h111111, SW, -1);
      compared++;
      if (rise_cyc - fall_cyc !== 2) begin
         mismatched++;
         $display("FAIL basic_latency: got %0d cycles required 2", rise_cyc - fall_cyc);
      end
      compared++;
      if (last_run !== 1) begin
         mismatched++;
         $display("FAIL basic_valid_width: got %0d required 1", last_run);
      end
      drive_slot(1'b1, 24'h222222, SW, -1);
      push_pair(24'h111111, 24'h222222);
   endtask

   task automatic test_overrun();
      int o0;
      drive_slot(1'b0, 24'h000001, SW, -1);
      pair.out_ready = 1'b0;
      drive_slot(1'b1, 24'h000002, SW, -1);
      push_pair(24'h000001, 24'h000002);
      drive_slot(1'b0, 24'h000003, SW, -1);
      drive_slot(1'b1, 24'h000004, SW, -1);
      o0 = ovr_pulses;
      drive_slot(1'b0, 24'h000005, SW, -1);
      compared++;
      if (ovr_pulses - o0 !== 1) begin
         mismatched++;
         $display("FAIL overrun_pulses: got %0d required 1", ovr_pulses - o0);
      end
      compared++;
      if (pair.out_valid !== 1'b1 || pair.out_left !== 24'h000001 || pair.out_right !== 24'h000002) begin
         mismatched++;
         $display("FAIL overrun_held: got valid=%b %h/%h required valid=1 000001/000002",
                  pair.out_valid, pair.out_left, pair.out_right);
      end
`ifdef I2S_RX_OVERRUN_CNT_EN
      compared++;
      if (overrun_cnt !== 16'd1) begin
         mismatched++;
         $display("FAIL overrun_cnt: got %0d required 1", overrun_cnt);
      end
`endif
      pair.out_ready = 1'b1;
      drive_slot(1'b1, 24'h000006, SW, -1);
      push_pair(24'h000005, 24'h000006);
   endtask

   task automatic test_frame_err();
      int f0;
      drive_slot(1'b0, 24'h000007, SW, -1);
      drive_slot(1'b1, 24'h89ABCD, 20, -1);
      push_pair(24'h000007, 24'h89ABC0);
      f0 = ferr_pulses;
      drive_slot(1'b0, 24'h000008, SW, -1);
      compared++;
      if (ferr_pulses - f0 !== 1) begin
         mismatched++;
         $display("FAIL frame_err_pulses: got %0d required 1", ferr_pulses - f0);
      end
      drive_slot(1'b1, 24'h000009, SW, -1);
      push_pair(24'h000008, 24'h000009);
   endtask

   task automatic test_back_to_back();
      int o0;
      pair.out_ready = 1'b0;
      drive_slot(1'b0, 24'h00000A, SW, -1);
      drive_slot(1'b1, 24'h00000B, SW, -1);
      push_pair(24'h00000A, 24'h00000B);
      o0 = ovr_pulses;
      drive_slot(1'b0, 24'h00000C, SW, 1);
      compared++;
      if (pop_cyc - prev_pop_cyc !== 1) begin
         mismatched++;
         $display("FAIL b2b_valid_gap: got %0d cycles between pairs required 1", pop_cyc - prev_pop_cyc);
      end
      compared++;
      if (ovr_pulses - o0 !== 0) begin
         mismatched++;
         $display("FAIL b2b_overrun: got %0d pulses required 0", ovr_pulses - o0);
      end
      drive_slot(1'b1, 24'h00000D, SW, -1);
      push_pair(24'h00000C, 24'h00000D);
   endtask

   task automatic test_reset_mid_left();
      pair.out_ready = 1'b0;
      drive_slot(1'b0, 24'h00000E, SW, -1);
      drive_slot(1'b1, 24'h00000F, SW, -1);
      drive_slot(1'b0, 24'h000010, 10, -1);
      @(negedge sclk);
      reset = 1'b1;
      #2;
      check_zero_outputs("reset_mid_left");
      exp_q.delete();
      drive_slot(1'b0, 24'h000010, 3, -1);
      reset = 1'b0;
      pair.out_ready = 1'b1;
      drive_slot(1'b0, 24'h000010, 19, -1);
      drive_slot(1'b1, 24'h000011, SW, -1);
      drive_slot(1'b0, 24'h000018, SW, -1);
      drive_slot(1'b1, 24'h000019, SW, -1);
      push_pair(24'h000018, 24'h000019);
   endtask

   task automatic test_reset_mid_right();
      drive_slot(1'b0, 24'h000020, SW, -1);
      drive_slot(1'b1, 24'h000021, 10, -1);
      @(negedge sclk);
      reset = 1'b1;
      drive_slot(1'b1, 24'h000021, 2, -1);
      reset = 1'b0;
      drive_slot(1'b1, 24'h000021, 20, -1);
      drive_slot(1'b0, 24'h000022, SW, -1);
      drive_slot(1'b1, 24'h000023, SW, -1);
      push_pair(24'h000022, 24'h000023);
      drive_slot(1'b0, 24'h000024, SW, -1);
      repeat (4) @(negedge sclk);
      compared++;
      if (exp_q.size() !== 0) begin
         mismatched++;
         $display("FAIL pairs_outstanding: got %0d left required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_left();
      test_reset_mid_right();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
